// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: 16 frames of one 32-bit word each.
// Hits are answered combinationally from IDLE. A miss latches the tag and
// index, then refills one word from the memory controller. The optional
// hit/miss statistics counters are enabled with the macro ICACHE_STATS_EN.
module icache_ctrl #(
  parameter int NFRAMES   = 16,
  parameter int FILL_HOLD = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hitcnt,
  output logic [31:0] misscnt
`endif
);

  localparam int C_IIX_W  = 4;
  localparam int C_IBYT_W = 2;
  localparam int C_ITAG_W = 32 - C_IIX_W - C_IBYT_W;
  localparam logic [1:0] HOLD_LAST = 2'(FILL_HOLD - 1);

  typedef struct packed {
    logic [C_ITAG_W-1:0] icpctag;
    logic [C_IIX_W-1:0]  icpcind;
    logic [C_IBYT_W-1:0] icpcbyt;
  } ic_pc_t;

  typedef struct packed {
    logic                icvalid;
    logic [C_ITAG_W-1:0] ictag;
    logic [31:0]         icblock;
  } ic_frame_t;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  if (NFRAMES != (1 << C_IIX_W)) begin : g_bad_nframes
    $error("icache_ctrl: NFRAMES must equal 2**C_IIX_W");
  end
  if (FILL_HOLD < 0 || FILL_HOLD > 3) begin : g_bad_fill_hold
    $error("icache_ctrl: FILL_HOLD must be in 0..3");
  end

  state_t              state_q;
  logic [C_ITAG_W-1:0] ltag_q;
  logic [C_IIX_W-1:0]  lidx_q;
  logic [1:0]          hold_q;
  ic_frame_t           frames_q [NFRAMES];

  ic_pc_t    pc;
  ic_frame_t sel;
  ic_frame_t frame_d;
  logic      lookup_hit;
  logic      fill_done;
  logic      unused_byte;

  assign pc          = ic_pc_t'(imemaddr);
  assign sel         = frames_q[pc.icpcind];
  assign lookup_hit  = imemREN && sel.icvalid && (sel.ictag == pc.icpctag);
  assign fill_done   = (state_q == FETCH) && !iwait;
  assign frame_d     = '{icvalid: 1'b1, ictag: ltag_q, icblock: iload};
  // Byte offset within the word plays no part in the lookup.
  assign unused_byte = ^pc.icpcbyt;

  assign ihit     = (state_q == IDLE) && lookup_hit;
  assign imemload = ihit ? sel.icblock : 32'h0;
  assign iREN     = (state_q == FETCH);
  assign iaddr    = iREN ? {ltag_q, lidx_q, 2'b00} : 32'h0;

  // Controller FSM: latch the missing line, wait for the fill, optional turnaround.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ltag_q  <= '0;
      lidx_q  <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            ltag_q  <= pc.icpctag;
            lidx_q  <= pc.icpcind;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            hold_q  <= '0;
            state_q <= (FILL_HOLD > 0) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame array: the only write is the refill landing at the end of FETCH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NFRAMES; i++) begin
        frames_q[i] <= '0;
      end
    end else if (fill_done) begin
      frames_q[lidx_q] <= frame_d;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit and miss counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hitcnt  <= '0;
      misscnt <= '0;
    end else begin
      if (ihit && (hitcnt != 32'hFFFF_FFFF)) begin
        hitcnt <= hitcnt + 32'd1;
      end
      if ((state_q == IDLE) && imemREN && !lookup_hit && (misscnt != 32'hFFFF_FFFF)) begin
        misscnt <= misscnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache sitting between the datapath fetch port and the memory controller's instruction port.
- Uses the shared cache package types: ic_pc_t decode, ic_frame_t storage, 16 frames of 1-word blocks.
- Serves hits in the same cycle; refills one word from memory on a miss.
- Downstream consumer is the memory controller arbiter, which returns iwait/iload.

Parameters:
- NFRAMES, 16, number of frames; must equal 2**C_IIX_W (elaboration error otherwise).
- FILL_HOLD, 0, extra idle cycles (0-3) inserted after a refill before re-evaluating, for memory-controller turnaround.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address (word_t)
- ihit  out  1  fetch served this cycle
- imemload  out  32  instruction word; valid only when ihit=1
- iREN  out  1  read request to memory controller
- iaddr  out  32  word-aligned refill address
- iwait  in  1  memory busy; low for one cycle = iload valid
- iload  in  32  refill data

Behaviour:
- Reset (async, nRST=0): all frames icvalid=0 (tag/block cleared to 0), state=IDLE, hold counter=0. ihit=0, iREN=0, iaddr=0, imemload=0.
- Decode: imemaddr cast to ic_pc_t; index=icpcind, tag=icpctag; byte offset is ignored.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - Hit = imemREN && frame[index].icvalid && frame[index].ictag==tag.
  - On hit: ihit=1 and imemload=frame[index].icblock, combinationally in the same cycle.
  - On miss with imemREN=1: latch {tag,index}, next state FETCH. ihit=0 during the miss cycle.
  - imemREN=0: ihit=0, imemload=0, stay IDLE.
- FETCH:
  - iREN=1; iaddr={latched tag, latched index, 2'b00}, held stable until the fill completes.
  - ihit=0 throughout.
  - When iwait=0: write frame[latched index] <= {1, latched tag, iload} at the clock edge. Next state HOLD if FILL_HOLD>0, else IDLE.
  - When iwait=1: stay in FETCH.
- HOLD: iREN=0, ihit=0; count FILL_HOLD cycles, then go to IDLE.
- Miss latency: one decode cycle + memory cycles until iwait=0 + FILL_HOLD. The hit is reported on the first IDLE cycle after the fill.
- A started refill always completes:
  - imemaddr changes or imemREN drops during FETCH: the fill still lands for the latched address; the new address is evaluated in IDLE.
- Conflict refill to an occupied index overwrites the tag/block unconditionally (read-only cache, no writeback).
- Frame array writes occur only on the FETCH-completion edge; no other write path.
- nRST asserted mid-FETCH: abort immediately, no frame written, iREN=0 asynchronously.
- iwait=0 seen while not in FETCH is ignored.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs hitcnt[31:0] and misscnt[31:0], both reset to 0.
  - hitcnt increments on each IDLE cycle with ihit=1.
  - misscnt increments on each IDLE->FETCH transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0x2002_0001.
  - Required: iREN=1 with iaddr=0x0000_0040 on cycles 2-5; ihit=1 with imemload=0x2002_0001 on cycle 6 (FILL_HOLD=0).
- Repeat hit: continue fetching 0x40, then 0x42 (same word).
  - Required: ihit=1 the same cycle; imemload=0x2002_0001; iREN stays 0.
- Conflict eviction: fill 0x40, then fetch 0x440 (index 0, tag 0x11) with iload=0xDEAD_BEEF, then 0x40 again.
  - Required: 0x440 misses and fills; 0x40 then misses again and re-issues iaddr=0x40.
- Address change mid-fill: miss on 0x80; switch imemaddr to 0x84 while iwait=1.
  - Required: iaddr stays 0x80 until iwait=0; frame index 0 holds 0x80's data; then a new miss for 0x84 with iaddr=0x84.
- Reset mid-FETCH: pull nRST low while iREN=1.
  - Required: iREN=0 immediately; after release, a fetch of the same address misses (frame was not written).
- With ICACHE_STATS_EN: run the cold-miss and repeat-hit scenarios (3 hit cycles).
  - Required: misscnt=1, hitcnt=4 (the post-fill hit plus 3).
